mem_copy_master: RTL and testbench
==================================

Name: mem_copy_master

Overview:
- Bus initiator (master) on the two-channel external-memory interface that HLS-generated cores use: Mout_oe_ram / Mout_we_ram / Mout_addr_ram / Mout_Wdata_ram / Mout_data_ram_size out, M_Rdata_ram / M_DataRdy in.
- Copies LEN bytes from SRC to DST: channel 0 reads, channel 1 writes.
- Exercises memory responders and testbench memory models, and serves as a reusable DMA-style helper alongside generated accelerators.
- Uses the same start_port / done_port handshake as generated top modules.

Parameters:
- ADDR_W, 11, per-channel address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 8, per-channel data width; transfers are one byte each.
- SIZE_W, 4, per-channel data_ram_size field width.
- LEN_W, 11, width of the byte-count input.
- TIMEOUT, 255, handshake watchdog limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start_port  in  1  start request, sampled in IDLE only.
- src_addr  in  ADDR_W  source base address, latched at start.
- dst_addr  in  ADDR_W  destination base address, latched at start.
- len  in  LEN_W  byte count, latched at start.
- done_port  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag, cleared by the next accepted start.
- Mout_oe_ram  out  2  read enables; bit 0 = channel 0.
- Mout_we_ram  out  2  write enables; bit 1 = channel 1.
- Mout_addr_ram  out  2*ADDR_W  channel 0 in [ADDR_W-1:0], channel 1 in upper half.
- Mout_Wdata_ram  out  2*DATA_W  write data; only channel 1 is used.
- Mout_data_ram_size  out  2*SIZE_W  access size in bits, per channel.
- M_Rdata_ram  in  2*DATA_W  read data; channel 0 is used.
- M_DataRdy  in  2  per-channel access-complete strobe.

Behaviour:
- Reset: on the edge where reset is sampled high, every output goes to 0 and the FSM returns to IDLE. An in-flight transfer is abandoned with no further requests.
- Idle bus: every Mout_* bit is 0 whenever no request is active, because the bus is OR-combined with other masters.
  - Bits 1 of oe and 0 of we are tied 0.
  - oe and we of the same channel are never high together.
- FSM states:
  - IDLE: start_port=1 latches src, dst and len, clears error and the byte counter, then goes to READ. If len=0 it goes straight to DONE.
  - READ:
    - Drives oe[0]=1, addr ch0 = src+cnt, size ch0 = 8.
    - Holds these until M_DataRdy[0] is sampled 1.
    - In that cycle, captures M_Rdata_ram[7:0] into the byte buffer, then goes to WRITE.
  - WRITE:
    - Drives we[1]=1, addr ch1 = dst+cnt, Wdata ch1 = buffer, size ch1 = 8.
    - Holds these until M_DataRdy[1]=1, then increments cnt.
    - Goes to DONE if cnt+1 == len, else back to READ.
  - DONE: done_port=1 for exactly one cycle, then IDLE.
- Request deassertion: oe/we drop in the cycle after the DataRdy cycle. Back-to-back requests on the same channel are therefore legal.
- Latency, against a responder with read delay 2 and write delay 1:
  - Take cycle 0 as the cycle start is sampled.
  - Each byte takes 3 cycles.
  - done_port is high in cycle 3*len+1; for len=0 it is high in cycle 1.
- Address arithmetic: ADDR_W-bit with silent wrap. Overlapping src/dst is copied in ascending order, with no overlap correction.
- start_port outside IDLE is ignored.
- A DataRdy on a channel with no active request is ignored.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter restarts on every READ/WRITE entry.
  - If DataRdy has not arrived after TIMEOUT cycles in the state, the FSM drops the request, sets error=1 and goes to DONE, so done_port still pulses.
- Without the macro: the FSM waits indefinitely, error is tied 0, and no counter logic is built.

Test Plan:
- Copy from src=0x010 to dst=0x100, len=4, bytes A1 B2 C3 D4, responder delays 2/1:
  - done_port is high in cycle 13 only.
  - Memory at 0x100..0x103 holds A1 B2 C3 D4.
  - oe[0] and we[1] are never both high on one channel, and no we[0]/oe[1] activity occurs.
- len=0: done_port is high in cycle 1, and Mout_* stays 0 throughout.
- Responder with read delay 5: each byte takes 6 cycles; len=2 gives done_port in cycle 13 and correct data.
- Wrap: src=0x7FF, dst=0x7FE, len=3:
  - Reads hit 0x7FF, 0x000, 0x001.
  - Writes hit 0x7FE, 0x7FF, 0x000 (the 0x7FF write follows its read).
- reset raised during the second READ of a len=4 copy: all outputs are 0 from the next cycle, and only byte 0 has been written. A subsequent start runs a clean copy.
- MEM_TIMEOUT_EN defined, responder holds M_DataRdy=0: error=1 and done_port pulse 256 cycles after READ entry. The next start clears error.

Source files
------------

// File: rtl/mem_copy_master.sv
// mem_copy_master
//   Byte-wise memory copy initiator for the two-channel external-memory bus
//   used by HLS-generated cores. Channel 0 only reads, channel 1 only writes.
//   Copies len bytes from src_addr to dst_addr in ascending order. Addresses
//   wrap modulo 2^ADDR_W. Overlapping regions are not corrected.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start_port            start request, accepted in IDLE only
//   src_addr, dst_addr    base addresses, latched at start
//   len                   byte count, latched at start (0 = no transfer)
//   done_port             one-cycle completion pulse
//   error                 sticky handshake timeout flag (0 without MEM_TIMEOUT_EN)
//   Mout_oe_ram           read enables   (bit 0 = channel 0; bit 1 tied 0)
//   Mout_we_ram           write enables  (bit 1 = channel 1; bit 0 tied 0)
//   Mout_addr_ram         {ch1 addr, ch0 addr}
//   Mout_Wdata_ram        {ch1 write data, 0}
//   Mout_data_ram_size    {ch1 size, ch0 size}, access size in bits
//   M_Rdata_ram           {ch1 data (unused), ch0 read data}
//   M_DataRdy             per-channel access-complete strobe
//
// Build option
//   MEM_TIMEOUT_EN : when defined, a READ or WRITE that sees no DataRdy for
//   TIMEOUT cycles is abandoned; error is set and done_port still pulses.

module mem_copy_master #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int LEN_W   = 11,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_port,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  done_port,
  output logic                  error,
  output logic [1:0]            Mout_oe_ram,
  output logic [1:0]            Mout_we_ram,
  output logic [2*ADDR_W-1:0]   Mout_addr_ram,
  output logic [2*DATA_W-1:0]   Mout_Wdata_ram,
  output logic [2*SIZE_W-1:0]   Mout_data_ram_size,
  input  logic [2*DATA_W-1:0]   M_Rdata_ram,
  input  logic [1:0]            M_DataRdy
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   buf_q, buf_d;
  logic [LEN_W-1:0]    cnt_inc;
  logic [ADDR_W-1:0]   cnt_addr;
  logic                rd_act, wr_act;

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                error_q, error_d;
  logic                tmo_hit;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT));
`endif

  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign cnt_addr = ADDR_W'(cnt_q);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
`ifdef MEM_TIMEOUT_EN
    error_d = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_port) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = len;
          cnt_d   = '0;
`ifdef MEM_TIMEOUT_EN
          error_d = 1'b0;
`endif
          state_d = (len == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (M_DataRdy[0]) begin
          buf_d   = M_Rdata_ram[DATA_W-1:0];
          state_d = S_WRITE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_WRITE: begin
        if (M_DataRdy[1]) begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == len_q) ? S_DONE : S_READ;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmo_hit) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      default: state_d = S_IDLE;  // S_DONE: single-cycle pulse
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  // Counts cycles spent waiting in the current READ/WRITE visit; any state
  // change (including READ->WRITE->READ) restarts it.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_READ || state_q == S_WRITE) && state_d == state_q)
      tmo_d = tmo_q + TW'(1);
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      tmo_q   <= '0;
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
`ifdef MEM_TIMEOUT_EN
      tmo_q   <= tmo_d;
      error_q <= error_d;
`endif
    end
  end

  // Bus outputs are decoded from the state register only, so every field is
  // zero outside an active request (the bus is OR-combined with other masters).
  assign rd_act = (state_q == S_READ);
  assign wr_act = (state_q == S_WRITE);

  assign done_port          = (state_q == S_DONE);
  assign Mout_oe_ram        = {1'b0, rd_act};
  assign Mout_we_ram        = {wr_act, 1'b0};
  assign Mout_addr_ram      = {wr_act ? (dst_q + cnt_addr) : {ADDR_W{1'b0}},
                               rd_act ? (src_q + cnt_addr) : {ADDR_W{1'b0}}};
  assign Mout_Wdata_ram     = {wr_act ? buf_q : {DATA_W{1'b0}}, {DATA_W{1'b0}}};
  assign Mout_data_ram_size = {wr_act ? SIZE_W'(DATA_W) : {SIZE_W{1'b0}},
                               rd_act ? SIZE_W'(DATA_W) : {SIZE_W{1'b0}}};

`ifdef MEM_TIMEOUT_EN
  assign error = error_q;
  logic unused_ok;
  assign unused_ok = ^{M_Rdata_ram[2*DATA_W-1:DATA_W]};
`else
  assign error = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{M_Rdata_ram[2*DATA_W-1:DATA_W], TIMEOUT[0]};
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master with a byte memory responder whose read
// and write delays are adjustable (delay d = DataRdy in the d-th request cycle,
// 0 = never).
module tb_mem_copy_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_port = 1'b0;
  logic [10:0] src_addr = '0, dst_addr = '0, len = '0;
  logic        done_port, error;
  logic [1:0]  Mout_oe_ram, Mout_we_ram;
  logic [21:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_copy_master dut (
    .clock(clk), .reset(reset), .start_port(start_port),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .done_port(done_port), .error(error),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
    .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy)
  );

  // ---------------- responder / memory model ----------------
  logic [7:0]  mem [0:2047];
  int          rd_dly = 2, wr_dly = 1;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [1:0]  spur = 2'b00;
  logic        pl_en = 1'b0;
  logic [10:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;
  logic [10:0] rd_log [0:63];
  logic [10:0] wr_log [0:63];
  int          rd_n = 0, wr_n = 0;
  logic [1:0]  rdy_real;

  assign rdy_real[0] = Mout_oe_ram[0] && rd_dly != 0 && rd_cnt == rd_dly - 1;
  assign rdy_real[1] = Mout_we_ram[1] && wr_dly != 0 && wr_cnt == wr_dly - 1;
  assign M_DataRdy   = rdy_real | spur;
  assign M_Rdata_ram = {8'h5A, mem[Mout_addr_ram[10:0]]};

  always @(posedge clk) begin
    rd_cnt <= (Mout_oe_ram[0] && !rdy_real[0]) ? rd_cnt + 1 : 0;
    wr_cnt <= (Mout_we_ram[1] && !rdy_real[1]) ? wr_cnt + 1 : 0;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (Mout_we_ram[1] && M_DataRdy[1]) begin
      mem[Mout_addr_ram[21:11]] <= Mout_Wdata_ram[15:8];
      wr_log[wr_n % 64] <= Mout_addr_ram[21:11];
      wr_n <= wr_n + 1;
    end
    if (Mout_oe_ram[0] && M_DataRdy[0]) begin
      rd_log[rd_n % 64] <= Mout_addr_ram[10:0];
      rd_n <= rd_n + 1;
    end
  end

  function automatic bit bus_idle();
    return Mout_oe_ram == 2'b00 && Mout_we_ram == 2'b00 && Mout_addr_ram == '0 &&
           Mout_Wdata_ram == '0 && Mout_data_ram_size == '0;
  endfunction

  task automatic poke(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives start so that it is sampled on the next rising edge (cycle 0) and
  // returns at the falling edge inside cycle 1 with start still high.
  task automatic do_start(input logic [10:0] s, input logic [10:0] d, input logic [10:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len = l; start_port = 1'b1;
    @(negedge clk);
    src_addr = 11'h7F0; dst_addr = 11'h7F0; len = 11'd9;  // junk: must not relatch
  endtask

  // Runs a copy for maxc cycles, holding start high through cycle hold-1.
  task automatic run_copy(input logic [10:0] s, input logic [10:0] d, input logic [10:0] l,
                          input int hold, input int maxc,
                          output int first_done, output int ndone, output int viol,
                          output int active, output logic err_at_done);
    first_done = -1; ndone = 0; viol = 0; active = 0; err_at_done = 1'bx;
    do_start(s, d, l);
    for (int n = 1; n <= maxc; n++) begin
      if (n >= hold) start_port = 1'b0;
      if (done_port) begin
        if (first_done < 0) begin first_done = n; err_at_done = error; end
        ndone++;
      end
      if (Mout_oe_ram[0] || Mout_we_ram[1]) active++;
      if (Mout_oe_ram[1] || Mout_we_ram[0] || Mout_Wdata_ram[7:0] != 0) viol++;
      if (!Mout_oe_ram[0] && (Mout_addr_ram[10:0] != 0 || Mout_data_ram_size[3:0] != 0)) viol++;
      if (!Mout_we_ram[1] && (Mout_addr_ram[21:11] != 0 || Mout_data_ram_size[7:4] != 0 ||
                              Mout_Wdata_ram[15:8] != 0)) viol++;
      if (Mout_oe_ram[0] && Mout_data_ram_size[3:0] != 4'd8) viol++;
      if (Mout_we_ram[1] && Mout_data_ram_size[7:4] != 4'd8) viol++;
      if (n < maxc) @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (done_port !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_port); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    total++; if (bus_idle() !== 1'b1) begin bad++;
      $display("FAIL reset_bus oe=%b we=%b addr=%h got nonzero exp all 0", Mout_oe_ram, Mout_we_ram, Mout_addr_ram); end
    reset = 1'b0;
    $display("test_reset: done=%b error=%b oe=%b we=%b", done_port, error, Mout_oe_ram, Mout_we_ram);
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    int fd, nd, vi, ac, w0; logic ed;
    for (int i = 0; i < 4; i++) begin poke(11'h010 + 11'(i), exp_b[i]); poke(11'h100 + 11'(i), 8'hEE); end
    rd_dly = 2; wr_dly = 1; w0 = wr_n;
    run_copy(11'h010, 11'h100, 11'd4, 3, 20, fd, nd, vi, ac, ed);
    total++; if (fd !== 13) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=13", fd); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", nd); end
    total++; if (vi !== 0) begin bad++; $display("FAIL basic_bus_rules got=%0d violations exp=0", vi); end
    total++; if (ed !== 1'b0) begin bad++; $display("FAIL basic_error got=%b exp=0", ed); end
    total++; if (wr_n - w0 !== 4) begin bad++; $display("FAIL basic_writes got=%0d exp=4", wr_n - w0); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem[11'h100 + 11'(i)] !== exp_b[i]) begin bad++;
        $display("FAIL basic_mem[%0d] got=%h exp=%h", i, mem[11'h100 + 11'(i)], exp_b[i]); end
    end
    $display("test_basic: done_cycle=%0d pulses=%0d writes=%0d", fd, nd, wr_n - w0);
  endtask

  task automatic test_len0();
    int fd, nd, vi, ac; logic ed;
    run_copy(11'h020, 11'h200, 11'd0, 1, 6, fd, nd, vi, ac, ed);
    total++; if (fd !== 1) begin bad++; $display("FAIL len0_done_cycle got=%0d exp=1", fd); end
    total++; if (nd !== 1) begin bad++; $display("FAIL len0_done_pulses got=%0d exp=1", nd); end
    total++; if (ac !== 0 || vi !== 0) begin bad++;
      $display("FAIL len0_bus_quiet got active=%0d viol=%0d exp 0/0", ac, vi); end
    $display("test_len0: done_cycle=%0d active=%0d", fd, ac);
  endtask

  task automatic test_slow_read();
    int fd, nd, vi, ac; logic ed;
    poke(11'h030, 8'h5A); poke(11'h031, 8'h6B);
    poke(11'h300, 8'hEE); poke(11'h301, 8'hEE);
    rd_dly = 5; spur = 2'b10;  // stray ch1 strobe while reading must be ignored
    run_copy(11'h030, 11'h300, 11'd2, 1, 16, fd, nd, vi, ac, ed);
    spur = 2'b00; rd_dly = 2;
    total++; if (fd !== 13) begin bad++; $display("FAIL slow_done_cycle got=%0d exp=13", fd); end
    total++; if (mem[11'h300] !== 8'h5A || mem[11'h301] !== 8'h6B) begin bad++;
      $display("FAIL slow_data got=%h%h exp=5a6b", mem[11'h300], mem[11'h301]); end
    $display("test_slow_read: done_cycle=%0d data=%h %h", fd, mem[11'h300], mem[11'h301]);
  endtask

  task automatic test_wrap();
    logic [10:0] exp_r [3] = '{11'h7FF, 11'h000, 11'h001};
    logic [10:0] exp_w [3] = '{11'h7FE, 11'h7FF, 11'h000};
    int fd, nd, vi, ac, r0, w0; logic ed;
    poke(11'h7FE, 8'h99); poke(11'h7FF, 8'h11); poke(11'h000, 8'h22); poke(11'h001, 8'h33);
    r0 = rd_n; w0 = wr_n;
    run_copy(11'h7FF, 11'h7FE, 11'd3, 1, 12, fd, nd, vi, ac, ed);
    total++; if (fd !== 10) begin bad++; $display("FAIL wrap_done_cycle got=%0d exp=10", fd); end
    for (int k = 0; k < 3; k++) begin
      total++; if (rd_log[(r0 + k) % 64] !== exp_r[k]) begin bad++;
        $display("FAIL wrap_read_addr[%0d] got=%h exp=%h", k, rd_log[(r0 + k) % 64], exp_r[k]); end
      total++; if (wr_log[(w0 + k) % 64] !== exp_w[k]) begin bad++;
        $display("FAIL wrap_write_addr[%0d] got=%h exp=%h", k, wr_log[(w0 + k) % 64], exp_w[k]); end
    end
    total++; if ({mem[11'h7FE], mem[11'h7FF], mem[11'h000]} !== 24'h112233) begin bad++;
      $display("FAIL wrap_data got=%h%h%h exp=112233", mem[11'h7FE], mem[11'h7FF], mem[11'h000]); end
    $display("test_wrap: done_cycle=%0d reads=%0d writes=%0d", fd, rd_n - r0, wr_n - w0);
  endtask

  task automatic test_reset_mid();
    int w0, idle_bad, fd, nd, vi, ac; logic ed; logic ph;
    for (int i = 0; i < 4; i++) poke(11'h500 + 11'(i), 8'hEE);
    w0 = wr_n; idle_bad = 0;
    do_start(11'h010, 11'h500, 11'd4);
    start_port = 1'b0;                     // now in cycle 1
    repeat (3) @(negedge clk);             // cycle 4: second READ
    ph = Mout_oe_ram[0] && Mout_addr_ram[10:0] == 11'h011;
    total++; if (ph !== 1'b1) begin bad++;
      $display("FAIL midreset_second_read got oe=%b addr=%h exp oe=1 addr=011", Mout_oe_ram[0], Mout_addr_ram[10:0]); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus_idle() !== 1'b1 || done_port !== 1'b0) begin bad++;
      $display("FAIL midreset_outputs got oe=%b we=%b done=%b exp all 0", Mout_oe_ram, Mout_we_ram, done_port); end
    reset = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (!bus_idle() || done_port) idle_bad++;
    end
    total++; if (idle_bad !== 0) begin bad++; $display("FAIL midreset_stays_idle got=%0d busy cycles exp=0", idle_bad); end
    total++; if (wr_n - w0 !== 1 || mem[11'h500] !== 8'hA1 || mem[11'h501] !== 8'hEE) begin bad++;
      $display("FAIL midreset_partial got writes=%0d m0=%h m1=%h exp 1/a1/ee", wr_n - w0, mem[11'h500], mem[11'h501]); end
    run_copy(11'h010, 11'h500, 11'd4, 1, 16, fd, nd, vi, ac, ed);
    total++; if (fd !== 13 || {mem[11'h500], mem[11'h501], mem[11'h502], mem[11'h503]} !== 32'hA1B2C3D4) begin bad++;
      $display("FAIL midreset_recopy got done=%0d data=%h%h%h%h exp 13/a1b2c3d4",
               fd, mem[11'h500], mem[11'h501], mem[11'h502], mem[11'h503]); end
    $display("test_reset_mid: partial_writes=1 recopy_done_cycle=%0d", fd);
  endtask

  task automatic test_idle_rdy();
    int busy;
    busy = 0;
    @(negedge clk);
    spur = 2'b11;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (!bus_idle() || done_port) busy++;
    end
    spur = 2'b00;
    total++; if (busy !== 0) begin bad++; $display("FAIL idle_rdy_ignored got=%0d busy cycles exp=0", busy); end
    $display("test_idle_rdy: busy_cycles=%0d", busy);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int fd, nd, vi, ac; logic ed;
    rd_dly = 0;
    run_copy(11'h040, 11'h400, 11'd1, 1, 262, fd, nd, vi, ac, ed);
    rd_dly = 2;
    total++; if (fd !== 257) begin bad++; $display("FAIL timeout_done_cycle got=%0d exp=257", fd); end
    total++; if (ed !== 1'b1 || nd !== 1) begin bad++; $display("FAIL timeout_error got err=%b pulses=%0d exp 1/1", ed, nd); end
    run_copy(11'h040, 11'h400, 11'd0, 1, 3, fd, nd, vi, ac, ed);
    total++; if (ed !== 1'b0) begin bad++; $display("FAIL timeout_error_clear got=%b exp=0", ed); end
    $display("test_timeout: done_cycle=257 checked, error cleared=%b", ~ed);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len0();
    test_slow_read();
    test_wrap();
    test_reset_mid();
    test_idle_rdy();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
